song_reader: RTL and testbench

SONG_READER -- requirements
Module: song_reader

---
 rtl/song_reader_pkg.sv | 43 ++++
 rtl/song_rom.sv | 38 +++
 rtl/song_reader.sv | 167 ++++++++++++++++
 tb/tb_song_reader.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/song_reader_pkg.sv
// ---------------------------------------------------------------------------
// song_reader_pkg
// Shared definitions for the song reader slice:
//   NOTE_W / DUR_W / SONG_W  - field widths of a ROM word and the song select
//   ROM_W                    - full ROM word width, {note, duration}
//   state_t                  - sequencing FSM state encoding
//   rom_word()               - song table contents, used by song_rom
// Optional feature macro used by the slice: SONG_READER_EARLY_END_EN
// ---------------------------------------------------------------------------
package song_reader_pkg;

    localparam int NOTE_W = 6;
    localparam int DUR_W  = 6;
    localparam int SONG_W = 2;
    localparam int ROM_W  = NOTE_W + DUR_W;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        GAP   = 3'd3,
        WAIT  = 3'd4,
        DONE  = 3'd5
    } state_t;

    // Song table: note climbs by 7 semitone steps per entry (mod 64) and
    // each song is offset by 9; durations grow slowly with the index.
    // Entry 5 of song 0 carries a zero duration so the early-end path has
    // a word to react to.
    function automatic logic [ROM_W-1:0] rom_word(input int unsigned song_sel,
                                                  input int unsigned idx);
        logic [NOTE_W-1:0] n;
        logic [DUR_W-1:0]  d;
        n = NOTE_W'((12 + 7 * idx + 9 * song_sel) % 64);
        if (song_sel == 0 && idx == 5) begin
            d = '0;
        end else begin
            d = DUR_W'(4 + idx + 3 * song_sel);
        end
        return {n, d};
    endfunction

endpackage

// File: rtl/song_rom.sv
// ---------------------------------------------------------------------------
// song_rom
// Song table with a one-cycle synchronous read. The output register only
// updates when rd_en is high, so the last read word is held otherwise.
// Ports:
//   clk    - clock, rising edge
//   reset  - asynchronous active-low reset, clears the output register
//   rd_en  - read strobe
//   addr   - {song, note_idx}
//   data   - {note, duration}, valid the cycle after rd_en
// ---------------------------------------------------------------------------
module song_rom
    import song_reader_pkg::*;
#(
    parameter int NOTE_IDX_W = 5
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         rd_en,
    input  logic [SONG_W+NOTE_IDX_W-1:0] addr,
    output logic [ROM_W-1:0]             data
);

    logic [SONG_W-1:0]     song_sel;
    logic [NOTE_IDX_W-1:0] idx;

    assign song_sel = addr[NOTE_IDX_W +: SONG_W];
    assign idx      = addr[NOTE_IDX_W-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data <= '0;
        end else if (rd_en) begin
            data <= rom_word(32'(song_sel), 32'(idx));
        end
    end

endmodule

// File: rtl/song_reader.sv
// ---------------------------------------------------------------------------
// song_reader
// Walks through the notes of one of four songs and hands each note to the
// note player, waiting for the player's done flag between notes.
// Ports:
//   clk        - clock, all state updates on the rising edge
//   reset      - asynchronous active-low reset
//   play       - 1 = advance through the song, 0 = pause (freeze)
//   song       - song select
//   note_done  - player reports the current note has finished
//   new_note   - one-cycle load strobe to the player
//   note       - note index, valid with new_note, held otherwise
//   duration   - note length in 1/48 s beats, valid with new_note
//   song_done  - one-cycle pulse when the last note has completed
// Optional feature: define SONG_READER_EARLY_END_EN to end a song at the
// first ROM word whose duration is zero instead of playing it.
// ---------------------------------------------------------------------------
module song_reader
    import song_reader_pkg::*;
#(
    parameter int NOTE_IDX_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              play,
    input  logic [SONG_W-1:0] song,
    input  logic              note_done,
    output logic              new_note,
    output logic [NOTE_W-1:0] note,
    output logic [DUR_W-1:0]  duration,
    output logic              song_done
);

    state_t                state_q, state_d;
    logic [NOTE_IDX_W-1:0] idx_q, idx_d;
    logic [SONG_W-1:0]     song_q;
    logic                  strobe_q, strobe_d;
    logic                  song_done_q, done_pulse_d;
    logic                  rom_rd;
    logic [ROM_W-1:0]      rom_data;
    logic [NOTE_W-1:0]     rom_note, note_q;
    logic [DUR_W-1:0]      rom_dur, dur_q;
    logic                  song_changed;
    logic                  early_end;

    song_rom #(
        .NOTE_IDX_W (NOTE_IDX_W)
    ) u_rom (
        .clk   (clk),
        .reset (reset),
        .rd_en (rom_rd),
        .addr  ({song_q, idx_q}),
        .data  (rom_data)
    );

    assign rom_note = rom_data[ROM_W-1:DUR_W];
    assign rom_dur  = rom_data[DUR_W-1:0];

`ifdef SONG_READER_EARLY_END_EN
    assign early_end = (rom_dur == '0);
`else
    assign early_end = 1'b0;
`endif

    // The registered song copy trails the input by one edge, so any
    // difference outside IDLE means the user switched songs mid-play.
    assign song_changed = (state_q != IDLE) && (song != song_q);

    // The strobe is registered on the FETCH->LOAD edge; an early-end word
    // masks it in the same cycle the ROM data becomes visible.
    assign new_note  = strobe_q & ~early_end;
    assign note      = new_note ? rom_note : note_q;
    assign duration  = new_note ? rom_dur  : dur_q;
    assign song_done = song_done_q;

    // State, index and output registers, all with async active-low reset.
    // The held note/duration only capture words that were actually loaded.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            song_q      <= '0;
            strobe_q    <= 1'b0;
            song_done_q <= 1'b0;
            note_q      <= '0;
            dur_q       <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            song_q      <= song;
            strobe_q    <= strobe_d;
            song_done_q <= done_pulse_d;
            if (new_note) begin
                note_q <= rom_note;
                dur_q  <= rom_dur;
            end
        end
    end

    // Next-state logic. A song change overrides everything; otherwise each
    // state only advances while play is high, except DONE, which leaves
    // when play drops.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        strobe_d     = 1'b0;
        done_pulse_d = 1'b0;
        rom_rd       = 1'b0;
        if (song_changed) begin
            state_d = IDLE;
            idx_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    idx_d = '0;
                    if (play) begin
                        state_d = FETCH;
                    end
                end
                FETCH: begin
                    if (play) begin
                        rom_rd   = 1'b1;
                        strobe_d = 1'b1;
                        state_d  = LOAD;
                    end
                end
                LOAD: begin
                    if (play) begin
                        if (early_end) begin
                            state_d      = DONE;
                            done_pulse_d = 1'b1;
                        end else begin
                            state_d = GAP;
                        end
                    end
                end
                GAP: begin
                    if (play) begin
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (play && note_done) begin
                        if (&idx_q) begin
                            state_d      = DONE;
                            done_pulse_d = 1'b1;
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            state_d = FETCH;
                        end
                    end
                end
                DONE: begin
                    if (!play) begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_song_reader.sv
// ---------------------------------------------------------------------------
// tb_song_reader
// Self-checking bench for song_reader: reset values, a cycle-by-cycle
// vector table, hand-written multi-cycle sequences and randomized plays
// scored against the expected note list of each song.
// Honours SONG_READER_EARLY_END_EN when computing expected note lists.
// ---------------------------------------------------------------------------
module tb_song_reader;

    logic       clk       = 1'b0;
    logic       reset     = 1'b0;
    logic       play      = 1'b0;
    logic [1:0] song      = 2'd0;
    logic       note_done = 1'b0;
    logic       new_note;
    logic [5:0] note;
    logic [5:0] duration;
    logic       song_done;

    int vec_count  = 0;
    int miss_count = 0;

    logic [11:0] pulses[$];
    logic [11:0] expq[$];
    int          done_count  = 0;
    logic [11:0] last_loaded = 12'd0;
    logic        play_at_edge;

    typedef struct {
        logic       play;
        logic [1:0] song;
        logic       nd;
        logic       exp_nn;
        logic [5:0] exp_note;
        logic [5:0] exp_dur;
        logic       exp_sd;
    } vec_t;

    vec_t tbl[13];

    always #5 clk = ~clk;

    song_reader #(
        .NOTE_IDX_W (5)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .play      (play),
        .song      (song),
        .note_done (note_done),
        .new_note  (new_note),
        .note      (note),
        .duration  (duration),
        .song_done (song_done)
    );

    // Expected song table contents, straight from the song definitions.
    function automatic logic [11:0] expWord(input int s, input int i);
        int n;
        int d;
        n = (12 + 7 * i + 9 * s) % 64;
        d = (s == 0 && i == 5) ? 0 : 4 + i + 3 * s;
        return {n[5:0], d[5:0]};
    endfunction

    // The notes a full play of song s should produce, in order.
    task automatic buildExpected(input int s);
        logic [11:0] w;
        expq.delete();
        for (int i = 0; i < 32; i++) begin
            w = expWord(s, i);
`ifdef SONG_READER_EARLY_END_EN
            if (w[5:0] == 6'd0) break;
`endif
            expq.push_back(w);
        end
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        vec_count++;
        if (actual !== expected) begin
            miss_count++;
            $display("[TB] FAIL %s: actual %0d, required %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic p, input logic [1:0] s, input logic nd);
        @(negedge clk);
        play      = p;
        song      = s;
        note_done = nd;
    endtask

    task automatic doReset();
        @(negedge clk);
        reset     = 1'b0;
        play      = 1'b0;
        note_done = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        pulses.delete();
        done_count = 0;
    endtask

    task automatic compareSequence(input string tag);
        checkOutput({tag, "_pulse_count"}, pulses.size(), expq.size());
        checkOutput({tag, "_song_done_count"}, done_count, 1);
        for (int i = 0; i < expq.size(); i++) begin
            if (i < pulses.size()) begin
                checkOutput($sformatf("%s_note%0d", tag, i), int'(pulses[i]), int'(expq[i]));
            end
        end
    endtask

    // Monitor: collects every load, checks a load was issued while playing,
    // never overlaps song_done, and that note/duration hold between loads.
    always begin
        @(posedge clk);
        play_at_edge = play;
        #1;
        if (!reset) begin
            last_loaded = 12'd0;
        end else if (new_note) begin
            pulses.push_back({note, duration});
            last_loaded = {note, duration};
            checkOutput("issue_while_playing", int'(play_at_edge), 1);
            checkOutput("new_note_with_song_done", int'(song_done), 0);
        end else begin
            checkOutput("hold_note_duration", int'({note, duration}), int'(last_loaded));
        end
        if (song_done) done_count++;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, actual timeout, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          seen;
        int          last_nn;
        int          sd_at;
        int          cnt;
        int          lat;
        int          pause_events;
        int          s;
        logic [11:0] cap;

        // Reset values
        @(posedge clk);
        #1;
        checkOutput("reset_new_note", int'(new_note), 0);
        checkOutput("reset_song_done", int'(song_done), 0);
        checkOutput("reset_note", int'(note), 0);
        checkOutput("reset_duration", int'(duration), 0);
        @(negedge clk);
        reset = 1'b1;

        // Cycle-by-cycle table on song 0 with note_done mostly held high
        tbl[0]  = '{1'b1, 2'd0, 1'b1, 1'b0, 6'd0,  6'd0, 1'b0};
        tbl[1]  = '{1'b1, 2'd0, 1'b1, 1'b1, 6'd12, 6'd4, 1'b0};
        tbl[2]  = '{1'b1, 2'd0, 1'b1, 1'b0, 6'd12, 6'd4, 1'b0};
        tbl[3]  = '{1'b1, 2'd0, 1'b1, 1'b0, 6'd12, 6'd4, 1'b0};
        tbl[4]  = '{1'b1, 2'd0, 1'b1, 1'b0, 6'd12, 6'd4, 1'b0};
        tbl[5]  = '{1'b1, 2'd0, 1'b1, 1'b1, 6'd19, 6'd5, 1'b0};
        tbl[6]  = '{1'b0, 2'd0, 1'b1, 1'b0, 6'd19, 6'd5, 1'b0};
        tbl[7]  = '{1'b1, 2'd0, 1'b1, 1'b0, 6'd19, 6'd5, 1'b0};
        tbl[8]  = '{1'b0, 2'd0, 1'b1, 1'b0, 6'd19, 6'd5, 1'b0};
        tbl[9]  = '{1'b1, 2'd0, 1'b0, 1'b0, 6'd19, 6'd5, 1'b0};
        tbl[10] = '{1'b1, 2'd0, 1'b0, 1'b0, 6'd19, 6'd5, 1'b0};
        tbl[11] = '{1'b1, 2'd0, 1'b1, 1'b0, 6'd19, 6'd5, 1'b0};
        tbl[12] = '{1'b1, 2'd0, 1'b1, 1'b1, 6'd26, 6'd6, 1'b0};
        for (int k = 0; k < 13; k++) begin
            applyStimulus(tbl[k].play, tbl[k].song, tbl[k].nd);
            @(posedge clk);
            #1;
            checkOutput($sformatf("tbl%0d_new_note", k), int'(new_note), int'(tbl[k].exp_nn));
            checkOutput($sformatf("tbl%0d_note", k), int'(note), int'(tbl[k].exp_note));
            checkOutput($sformatf("tbl%0d_duration", k), int'(duration), int'(tbl[k].exp_dur));
            checkOutput($sformatf("tbl%0d_song_done", k), int'(song_done), int'(tbl[k].exp_sd));
        end

        // Asynchronous reset in the middle of a note, then restart at entry 0
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async_reset_new_note", int'(new_note), 0);
        checkOutput("async_reset_note", int'(note), 0);
        checkOutput("async_reset_duration", int'(duration), 0);
        checkOutput("async_reset_song_done", int'(song_done), 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("restart_fetch_new_note", int'(new_note), 0);
        @(posedge clk);
        #1;
        checkOutput("restart_new_note", int'(new_note), 1);
        checkOutput("restart_note", int'(note), 12);
        checkOutput("restart_duration", int'(duration), 4);

        // Full play of song 1 with note_done held high
        doReset();
        play = 1'b1; song = 2'd1; note_done = 1'b1;
        seen = 0; last_nn = -100; sd_at = -1;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk);
            #1;
            if (new_note) last_nn = c;
            if (song_done) begin
                sd_at = c;
                seen  = 1;
                break;
            end
        end
        repeat (6) @(posedge clk);
        @(negedge clk);
        checkOutput("song1_done_seen", seen, 1);
        checkOutput("song1_done_latency", sd_at - last_nn, 3);
        buildExpected(1);
        compareSequence("song1");

        // Pause for 10 cycles while waiting with note_done high
        doReset();
        play = 1'b1; song = 2'd3; note_done = 1'b0;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (new_note) begin
                seen = 1;
                break;
            end
        end
        checkOutput("pause_first_note_seen", seen, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        play = 1'b0; note_done = 1'b1;
        pause_events = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (new_note || song_done) pause_events++;
        end
        checkOutput("pause_quiet", pause_events, 0);
        @(negedge clk);
        play = 1'b1;
        lat = -1; cap = 12'd0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (new_note) begin
                lat = c;
                cap = {note, duration};
                break;
            end
        end
        checkOutput("resume_latency", lat, 1);
        checkOutput("resume_note", int'(cap), int'(expWord(3, 1)));

        // Song change from 2 to 3 while waiting on entry 7
        doReset();
        play = 1'b1; song = 2'd2; note_done = 1'b1;
        cnt = 0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk);
            #1;
            if (new_note) cnt++;
            if (cnt == 8) break;
        end
        @(negedge clk);
        note_done = 1'b0;
        repeat (3) @(negedge clk);
        song = 2'd3;
        lat = -1; cap = 12'd0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (new_note) begin
                lat = c;
                cap = {note, duration};
                break;
            end
        end
        @(negedge clk);
        checkOutput("switch_pulses_before", cnt, 8);
        checkOutput("switch_latency", lat, 2);
        checkOutput("switch_note", int'(cap), int'(expWord(3, 0)));
        for (int i = 0; i < 8; i++) begin
            if (i < pulses.size()) begin
                checkOutput($sformatf("switch_song2_note%0d", i), int'(pulses[i]), int'(expWord(2, i)));
            end
        end

        // Song 0 holds a zero-duration word at entry 5
        doReset();
        play = 1'b1; song = 2'd0; note_done = 1'b1;
        seen = 0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk);
            #1;
            if (song_done) begin
                seen = 1;
                break;
            end
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("song0_done_seen", seen, 1);
        buildExpected(0);
        compareSequence("song0");

        // Randomized plays with random pauses and note_done timing
        for (int run = 0; run < 6; run++) begin
            s = int'($urandom_range(3, 0));
            doReset();
            song = s[1:0];
            seen = 0;
            for (int c = 0; c < 4000; c++) begin
                @(negedge clk);
                play      = ($urandom_range(9, 0) < 8);
                note_done = ($urandom_range(2, 0) == 0);
                @(posedge clk);
                #1;
                if (song_done) begin
                    seen = 1;
                    break;
                end
            end
            @(negedge clk);
            play = 1'b0;
            @(negedge clk);
            checkOutput($sformatf("rand%0d_done_seen", run), seen, 1);
            buildExpected(s);
            compareSequence($sformatf("rand%0d_song%0d", run, s));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
